// File: rtl/counter_seq_ctrl.sv
// Sequencer for an up/down scope counter: prescaled step/load strobes that sweep
// the external counter between latched low/high limits in one of four modes.
module counter_seq_ctrl #(
  parameter int WIDTH = 6,
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  localparam logic [1:0] M_UP      = 2'd0;
  localparam logic [1:0] M_DOWN    = 2'd1;
  localparam logic [1:0] M_BOUNCE  = 2'd2;
  localparam logic [1:0] M_ONESHOT = 2'd3;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] psc_q, psc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             tick;
  logic             outside;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      psc_q   <= '0;
      div_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= M_UP;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      div_q   <= div_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign tick    = (psc_q == div_q);
  assign outside = (cnt_value < lo_q) || (cnt_value > hi_q);

  always_comb begin
    state_d      = state_q;
    psc_d        = psc_q;
    div_d        = div_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    err_d        = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        psc_d = '0;
        if (start) begin
          if (lo_lim > hi_lim) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode;
            lo_d    = lo_lim;
            hi_d    = hi_lim;
            div_d   = div;
            state_d = INIT;
          end
        end
      end
      INIT: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          cnt_load     = 1'b1;
          cnt_load_val = (mode_q == M_DOWN) ? hi_q : lo_q;
          dir_d        = (mode_q != M_DOWN);
          psc_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          psc_d = tick ? '0 : psc_q + DIV_W'(1);
          if (tick) begin
            unique case (mode_q)
              M_UP: begin
                if (cnt_value >= hi_q || cnt_value < lo_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = lo_q;
                end else begin
                  cnt_en = 1'b1;
                  dir_d  = 1'b1;
                end
              end
              M_DOWN: begin
                if (cnt_value <= lo_q || cnt_value > hi_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = hi_q;
                end else begin
                  cnt_en = 1'b1;
                  dir_d  = 1'b0;
                end
              end
              M_BOUNCE: begin
                // Turnaround flips direction and steps in the new direction on the same tick
                if (outside) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = lo_q;
                  dir_d        = 1'b1;
                end else if (lo_q != hi_q) begin
                  cnt_en = 1'b1;
                  if (dir_q && cnt_value >= hi_q)       dir_d = 1'b0;
                  else if (!dir_q && cnt_value <= lo_q) dir_d = 1'b1;
                end
              end
              M_ONESHOT: begin
                if (cnt_value >= hi_q) begin
                  state_d = DONE;
                end else begin
                  cnt_en = 1'b1;
                  dir_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Direction presented is the one taking effect at this edge, so a bounce step agrees with the flip
  assign cnt_dir = dir_d;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 6-bit counter closing the loop.
module tb_counter_seq_ctrl;
  localparam int WIDTH = 6;
  localparam int DIV_W = 24;

  logic             clock = 1'b0;
  logic             rst, start, stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo_lim, hi_lim;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] cnt;
  logic             cnt_en, cnt_dir, cnt_load, busy, done, err;
  logic [WIDTH-1:0] cnt_load_val;
  logic             preset;
  logic [WIDTH-1:0] preset_val;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clock(clock), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .div(div), .cnt_value(cnt),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // External counter: load beats enable
  always @(posedge clock) begin
    if (preset)        cnt <= preset_val;
    else if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_en)   cnt <= cnt_dir ? cnt + 6'd1 : cnt - 6'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input int lo, input int hi, input int d);
    mode   = m;
    lo_lim = WIDTH'(lo);
    hi_lim = WIDTH'(hi);
    div    = DIV_W'(d);
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  int up_exp [8] = '{3, 4, 5, 6, 3, 4, 5, 6};
  int clog [0:385];
  int dlog [0:385];
  int elog [0:385];
  int olog [0:12];
  int blog [0:12];
  int jumps, ens, dones, saved, diff;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    lo_lim = '0; hi_lim = '0; div = '0;
    preset = 1'b1; preset_val = 6'd40;
    cyc(); cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(cnt_en), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_load_val", int'(cnt_load_val), 0);
    chk("rst_dir", int'(cnt_dir), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0; preset = 1'b0;
    cyc();
    chk("idle_hold", int'(cnt), 40);

    // UP 3..6, div 0
    launch(2'd0, 3, 6, 0);
    chk("up_init_load", int'(cnt_load), 1);
    chk("up_init_val", int'(cnt_load_val), 3);
    chk("up_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("up_seq", int'(cnt), up_exp[i]);
      chk("up_dir", int'(cnt_dir), 1);
    end
    stop = 1'b1; #1;
    chk("up_stop_load", int'(cnt_load), 0);
    chk("up_stop_en", int'(cnt_en), 0);
    cyc(); stop = 1'b0;
    chk("up_stop_busy", int'(busy), 0);
    chk("up_stop_hold", int'(cnt), 6);

    // BOUNCE 0..63, div 2
    launch(2'd2, 0, 63, 2);
    chk("bnc_init_val", int'(cnt_load_val), 0);
    for (int k = 0; k <= 385; k++) begin
      cyc();
      clog[k] = int'(cnt); dlog[k] = int'(cnt_dir); elog[k] = int'(cnt_en);
    end
    jumps = 0;
    for (int k = 1; k <= 385; k++) begin
      diff = clog[k] - clog[k-1];
      if (diff > 1 || diff < -1) jumps++;
    end
    ens = 0;
    for (int k = 0; k < 30; k++) ens += elog[k];
    chk("bnc_no_wrap", jumps, 0);
    chk("bnc_rate", ens, 10);
    chk("bnc_62", clog[188], 62);
    chk("bnc_63", clog[189], 63);
    chk("bnc_63_hold", clog[191], 63);
    chk("bnc_dir_before", dlog[190], 1);
    chk("bnc_dir_flip_hi", dlog[191], 0);
    chk("bnc_down", clog[192], 62);
    chk("bnc_zero", clog[378], 0);
    chk("bnc_dir_flip_lo", dlog[380], 1);
    chk("bnc_up_again", clog[381], 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // ONESHOT 10..12, div 1
    launch(2'd3, 10, 12, 1);
    chk("os_init_val", int'(cnt_load_val), 10);
    for (int k = 0; k <= 12; k++) begin
      cyc();
      clog[k] = int'(cnt); elog[k] = int'(cnt_en);
      olog[k] = int'(done); blog[k] = int'(busy);
    end
    ens = 0; dones = 0;
    for (int k = 0; k <= 12; k++) begin
      ens += elog[k];
      dones += olog[k];
    end
    chk("os_11", clog[2], 11);
    chk("os_12", clog[4], 12);
    chk("os_last_tick_en", elog[5], 0);
    chk("os_done_at", olog[6], 1);
    chk("os_done_count", dones, 1);
    chk("os_busy_done", blog[6], 1);
    chk("os_busy_after", blog[7], 0);
    chk("os_strobes", ens, 2);
    chk("os_hold", clog[12], 12);

    // DOWN 5..25, div 3: stop on the tick at v = 20
    launch(2'd1, 5, 25, 3);
    chk("dn_init_val", int'(cnt_load_val), 25);
    for (int k = 0; k <= 23; k++) begin
      cyc();
      if (k == 19) chk("dn_tick_en", int'(cnt_en), 1);
      if (k == 20) chk("dn_20", int'(cnt), 20);
    end
    stop = 1'b1; #1;
    chk("dn_stop_en", int'(cnt_en), 0);
    chk("dn_stop_load", int'(cnt_load), 0);
    cyc(); stop = 1'b0;
    chk("dn_stop_busy", int'(busy), 0);
    chk("dn_stop_hold", int'(cnt), 20);
    cyc();
    chk("dn_stop_hold2", int'(cnt), 20);

    // Restart DOWN, then a start with new config while running
    launch(2'd1, 5, 25, 3);
    chk("dn2_init_val", int'(cnt_load_val), 25);
    chk("dn2_dir", int'(cnt_dir), 0);
    cyc();
    chk("dn2_reload", int'(cnt), 25);
    cyc();
    mode = 2'd0; lo_lim = 6'd0; hi_lim = 6'd63; div = '0; start = 1'b1;
    cyc(); start = 1'b0;
    chk("busy_start_err", int'(err), 0);
    chk("busy_start_hold", int'(cnt), 25);
    cyc(); cyc();
    chk("busy_start_step", int'(cnt), 24);
    chk("busy_start_dir", int'(cnt_dir), 0);
    repeat (4) cyc();
    chk("busy_start_div", int'(cnt), 23);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Rejected start
    saved = int'(cnt);
    mode = 2'd0; lo_lim = 6'd9; hi_lim = 6'd5; div = '0; start = 1'b1;
    cyc(); start = 1'b0;
    chk("bad_err", int'(err), 1);
    chk("bad_busy", int'(busy), 0);
    chk("bad_load", int'(cnt_load), 0);
    cyc();
    chk("bad_err_pulse", int'(err), 0);
    chk("bad_busy2", int'(busy), 0);
    chk("bad_hold", int'(cnt), saved);

    // Asynchronous reset mid-RUN
    launch(2'd0, 3, 6, 0);
    cyc(); cyc();
    @(posedge clock); #2;
    rst = 1'b1; #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_en", int'(cnt_en), 0);
    chk("arst_load", int'(cnt_load), 0);
    chk("arst_load_val", int'(cnt_load_val), 0);
    chk("arst_dir", int'(cnt_dir), 1);
    chk("arst_done", int'(done), 0);
    cyc(); rst = 1'b0;
    saved = int'(cnt);
    ens = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      ens += int'(cnt_en) + int'(cnt_load) + int'(busy);
    end
    chk("arst_idle", ens, 0);
    chk("arst_hold", int'(cnt), saved);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
